// File: rtl/branch_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : branch_issue_arbiter
// Brief    : Round-robin sharing of the single branch unit among NUM_REQ
//            issue sources. Sequences one branch at a time: arbitrate,
//            operand handshake, wait for resolution, optional flush.
//            res_i layout: [2] valid, [1] taken, [0] mispredict.
// Option   : `define BRANCH_ARB_PERF_EN to build the 32-bit saturating
//            resolved / mispredict performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_issue_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       bu_ops_valid_o,
  input  logic                       bu_ops_ready_i,
  input  logic [2:0]                 res_i,
  input  logic                       flush_i,
  output logic                       flush_o,
  output logic                       busy_o,
  output logic                       timeout_o,
  output logic [31:0]                issued_cnt_o,
  output logic [31:0]                mispred_cnt_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_RES = 3'd2;
  localparam logic [2:0] S_FLUSH    = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_ptr_after_grant;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_tmo_expired;
  logic             w_any_req;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W:0]   w_sum;
  logic             w_grant_load;
  logic             w_ptr_adv;
  logic             w_cnt_clr;
  logic             w_tmo_fire;
  logic             w_res_accept;
  logic             w_res_valid;
  logic             w_res_mispred;
  logic             w_unused_taken;

  assign w_res_valid    = res_i[2];
  assign w_res_mispred  = res_i[0];
  assign w_unused_taken = res_i[1];

  assign w_tmo_expired     = (r_tmo_cnt == TMO_LAST);
  assign w_ptr_after_grant = (grant_idx_o == IDX_W'(NUM_REQ - 1)) ? '0
                                                                   : grant_idx_o + IDX_W'(1);

  // Round-robin pick: first asserted request at or after the pointer, wrapping.
  always_comb begin
    w_any_req = 1'b0;
    w_pick    = '0;
    w_sum     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      end
      if (!w_any_req && req_valid_i[w_sum[IDX_W-1:0]]) begin
        w_any_req = 1'b1;
        w_pick    = w_sum[IDX_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and sequencing strobes; an external flush takes priority over
  // resolution/timeout because the in-flight branch is being thrown away.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_load = 1'b0;
    w_ptr_adv    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_tmo_fire   = 1'b0;
    w_res_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant_load = 1'b1;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bu_ops_ready_i) begin
          // Handshake completes even under flush; its result must be drained.
          w_cnt_clr   = 1'b1;
          w_state_nxt = flush_i ? S_DRAIN : S_WAIT_RES;
        end else if (flush_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_RES: begin
        if (flush_i) begin
          if (w_res_valid) begin
            w_ptr_adv   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_DRAIN;
          end
        end else if (w_res_valid) begin
          w_ptr_adv    = 1'b1;
          w_res_accept = 1'b1;
          w_state_nxt  = w_res_mispred ? S_FLUSH : S_IDLE;
        end else if (w_tmo_expired) begin
          w_ptr_adv   = 1'b1;
          w_tmo_fire  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (w_res_valid) begin
          w_ptr_adv   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_expired) begin
          w_ptr_adv   = 1'b1;
          w_tmo_fire  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from state; ready pulse is the ISSUE handshake.
  always_comb begin
    req_ready_o    = '0;
    bu_ops_valid_o = 1'b0;
    flush_o        = 1'b0;
    busy_o         = (r_state != S_IDLE);
    case (r_state)
      S_ISSUE: begin
        bu_ops_valid_o = 1'b1;
        if (bu_ops_ready_i) begin
          req_ready_o[grant_idx_o] = 1'b1;
        end
      end
      S_FLUSH: begin
        flush_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Grant index, round-robin pointer, resolution timer and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant_idx_o <= '0;
      r_rr_ptr    <= '0;
      r_tmo_cnt   <= '0;
      timeout_o   <= 1'b0;
    end else begin
      if (w_grant_load) begin
        grant_idx_o <= w_pick;
      end
      if (w_ptr_adv) begin
        r_rr_ptr <= w_ptr_after_grant;
      end
      if (w_cnt_clr) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == S_WAIT_RES || r_state == S_DRAIN) && !w_tmo_expired) begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end
      if (w_tmo_fire) begin
        timeout_o <= 1'b1;
      end
    end
  end

`ifdef BRANCH_ARB_PERF_EN
  logic [31:0] r_issued_cnt;
  logic [31:0] r_mispred_cnt;

  // Saturating counters for accepted (non-discarded) resolutions.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_issued_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_res_accept) begin
      if (r_issued_cnt != 32'hFFFF_FFFF) begin
        r_issued_cnt <= r_issued_cnt + 32'd1;
      end
      if (w_res_mispred && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  assign issued_cnt_o  = r_issued_cnt;
  assign mispred_cnt_o = r_mispred_cnt;
`else
  logic w_unused_accept;

  assign w_unused_accept = w_res_accept;
  assign issued_cnt_o    = '0;
  assign mispred_cnt_o   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_issue_arbiter
// Brief    : Self-checking bench for branch_issue_arbiter. Table of branch
//            transactions plus hand-written flush / timeout / reset sequences;
//            expected grants go through a scoreboard queue checked on each
//            req_ready_o pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_issue_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int TIMEOUT_CYC = 16;
`ifdef BRANCH_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready_o;
  logic [1:0]  grant_idx_o;
  logic        bu_ops_valid_o;
  logic        bu_ready;
  logic [2:0]  res;
  logic        flush_in;
  logic        flush_o;
  logic        busy_o;
  logic        timeout_o;
  logic [31:0] issued_cnt_o;
  logic [31:0] mispred_cnt_o;

  always #5 clk = ~clk;

  branch_issue_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .grant_idx_o    (grant_idx_o),
    .bu_ops_valid_o (bu_ops_valid_o),
    .bu_ops_ready_i (bu_ready),
    .res_i          (res),
    .flush_i        (flush_in),
    .flush_o        (flush_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o),
    .issued_cnt_o   (issued_cnt_o),
    .mispred_cnt_o  (mispred_cnt_o)
  );

  typedef struct {
    logic [3:0] req;
    logic       mis;
    int         exp_grant;
    logic       exp_flush;
  } vec_t;

  vec_t vecs[11];
  int   sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mon_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_hs(input string tag, output logic [3:0] got);
    int n = 0;
    got = '0;
    do begin
      @(negedge clk);
      n++;
      got = req_ready_o;
    end while (got == '0 && n < 10);
    chk({tag, "_handshake"}, 32'(got != '0), 32'd1);
  endtask

  // One complete branch: request, handshake, resolution, optional flush.
  task automatic run_txn(input logic [3:0] req, input logic mis, input int exp_g,
                         input logic exp_fl, input string tag);
    logic [3:0] got;
    sb_q.push_back(exp_g);
    @(posedge clk); #1;
    req_valid = req;
    bu_ready  = 1'b1;
    wait_hs(tag, got);
    chk({tag, "_ops_valid"}, 32'(bu_ops_valid_o), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    bu_ready  = 1'b0;
    res       = {1'b1, 1'b0, mis};
    @(posedge clk); #1;
    res = '0;
    @(negedge clk);
    chk({tag, "_flush"}, 32'(flush_o), 32'(exp_fl));
    if (exp_fl) begin
      @(negedge clk);
      chk({tag, "_flush_one_cycle"}, 32'(flush_o), 32'd0);
    end
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [3:0] got;
    int         n;

    rst_n     = 1'b0;
    req_valid = '0;
    bu_ready  = 1'b0;
    res       = '0;
    flush_in  = 1'b0;

    vecs[0]  = '{4'b0100, 1'b0, 2, 1'b0};
    vecs[1]  = '{4'b1001, 1'b0, 3, 1'b0};
    vecs[2]  = '{4'b1111, 1'b0, 0, 1'b0};
    vecs[3]  = '{4'b1111, 1'b0, 1, 1'b0};
    vecs[4]  = '{4'b1111, 1'b0, 2, 1'b0};
    vecs[5]  = '{4'b1111, 1'b0, 3, 1'b0};
    vecs[6]  = '{4'b1111, 1'b0, 0, 1'b0};
    vecs[7]  = '{4'b0001, 1'b1, 0, 1'b1};
    vecs[8]  = '{4'b1010, 1'b0, 1, 1'b0};
    vecs[9]  = '{4'b0011, 1'b1, 0, 1'b1};
    vecs[10] = '{4'b1000, 1'b0, 3, 1'b0};

    fork
      forever begin
        @(negedge clk);
        if (rst_n && req_ready_o != '0) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_ready", 32'(req_ready_o), 32'd0);
          end else begin
            mon_g = sb_q.pop_front();
            chk("sb_ready_onehot", 32'(req_ready_o), 32'd1 << mon_g);
            chk("sb_grant_idx", 32'(grant_idx_o), 32'(mon_g));
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready",     32'(req_ready_o),    32'd0);
    chk("rst_grant",     32'(grant_idx_o),    32'd0);
    chk("rst_ops_valid", 32'(bu_ops_valid_o), 32'd0);
    chk("rst_flush",     32'(flush_o),        32'd0);
    chk("rst_busy",      32'(busy_o),         32'd0);
    chk("rst_timeout",   32'(timeout_o),      32'd0);
    chk("rst_issued",    issued_cnt_o,        32'd0);
    chk("rst_mispred",   mispred_cnt_o,       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].req, vecs[i].mis, vecs[i].exp_grant, vecs[i].exp_flush,
              $sformatf("vec%0d", i));
    end
    chk("tbl_issued",  issued_cnt_o,  PERF ? 32'd11 : 32'd0);
    chk("tbl_mispred", mispred_cnt_o, PERF ? 32'd2  : 32'd0);

    // Flush while waiting for resolution; mispredicting result arrives in DRAIN.
    sb_q.push_back(1);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    bu_ready  = 1'b1;
    wait_hs("drain", got);
    @(posedge clk); #1;
    req_valid = '0;
    bu_ready  = 1'b0;
    flush_in  = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    res      = 3'b101;
    @(negedge clk);
    chk("drain_busy",  32'(busy_o),  32'd1);
    chk("drain_flush", 32'(flush_o), 32'd0);
    @(posedge clk); #1;
    res = '0;
    @(negedge clk);
    chk("drain_idle",     32'(busy_o),  32'd0);
    chk("drain_no_flush", 32'(flush_o), 32'd0);
    chk("drain_issued",   issued_cnt_o,  PERF ? 32'd11 : 32'd0);
    chk("drain_mispred",  mispred_cnt_o, PERF ? 32'd2  : 32'd0);

    // Flush in ISSUE without handshake: abort, then same index re-granted.
    @(posedge clk); #1;
    req_valid = 4'b1100;
    bu_ready  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bu_ops_valid_o && n < 10);
    chk("abort_issue_reached", 32'(bu_ops_valid_o), 32'd1);
    chk("abort_grant",         32'(grant_idx_o),    32'd2);
    @(posedge clk); #1;
    flush_in = 1'b1;
    @(negedge clk);
    chk("abort_no_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1;
    flush_in = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(busy_o), 32'd0);
    sb_q.push_back(2);
    bu_ready = 1'b1;
    wait_hs("regrant", got);
    @(posedge clk); #1;
    req_valid = '0;
    bu_ready  = 1'b0;
    res       = 3'b100;
    @(posedge clk); #1;
    res = '0;
    @(negedge clk);
    chk("regrant_idle",   32'(busy_o),  32'd0);
    chk("regrant_issued", issued_cnt_o, PERF ? 32'd12 : 32'd0);

    // Resolution timeout: exactly TIMEOUT_CYC cycles in WAIT_RES.
    sb_q.push_back(0);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    bu_ready  = 1'b1;
    wait_hs("tmo", got);
    @(posedge clk); #1;
    req_valid = '0;
    bu_ready  = 1'b0;
    chk("tmo_before", 32'(timeout_o), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      if (busy_o) n++;
    end while (busy_o && n < 40);
    chk("tmo_cycles",  32'(n),         32'(TIMEOUT_CYC));
    chk("tmo_set",     32'(timeout_o), 32'd1);
    chk("tmo_flush",   32'(flush_o),   32'd0);
    repeat (3) @(negedge clk);
    chk("tmo_sticky",  32'(timeout_o), 32'd1);
    chk("tmo_idle",    32'(busy_o),    32'd0);
    chk("tmo_issued",  issued_cnt_o,   PERF ? 32'd12 : 32'd0);

    // Asynchronous reset in the middle of ISSUE.
    @(posedge clk); #1;
    req_valid = 4'b0010;
    bu_ready  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bu_ops_valid_o && n < 10);
    chk("arst_issue_reached", 32'(bu_ops_valid_o), 32'd1);
    chk("arst_grant_before",  32'(grant_idx_o),    32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ops_valid", 32'(bu_ops_valid_o), 32'd0);
    chk("arst_grant",     32'(grant_idx_o),    32'd0);
    chk("arst_busy",      32'(busy_o),         32'd0);
    chk("arst_timeout",   32'(timeout_o),      32'd0);
    chk("arst_ready",     32'(req_ready_o),    32'd0);
    chk("arst_issued",    issued_cnt_o,        32'd0);
    chk("arst_mispred",   mispred_cnt_o,       32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b1;
    repeat (2) @(negedge clk);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
